reorder_buffer: RTL and testbench

In-order completion buffer for the Tomasulo core. The decoder allocates an entry per instruction and receives its tag, which the reservation station carries to its ALU and returns on the CDB. The buffer captures results from the RS and LSB CDB ports and answers operand-readiness queries at issue. It retires at most one instruction per cycle, broadcasting commit_lab/commit_val to the reservation station and register file, and raises flush on a mispredicted branch.

---
 rtl/reorder_buffer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order completion buffer: allocates tagged entries at issue, captures
// CDB results, forwards operand readiness, and retires one entry per cycle.
// A committing mispredicted branch empties the buffer and redirects fetch.
module reorder_buffer #(
  parameter int ROB_ID_WIDTH = 3,
  parameter int VAL_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    dec2rob_en,
  input  logic [4:0]              dec_rd,
  input  logic                    dec_is_store,
  input  logic                    dec_is_branch,
  output logic                    rob_full,
  output logic [ROB_ID_WIDTH:0]   newTag,
  input  logic [ROB_ID_WIDTH:0]   q_lab1,
  input  logic [ROB_ID_WIDTH:0]   q_lab2,
  output logic                    ready1,
  output logic                    ready2,
  output logic [VAL_WIDTH-1:0]    res1,
  output logic [VAL_WIDTH-1:0]    res2,
  input  logic                    rs_cdb_en,
  input  logic [ROB_ID_WIDTH:0]   rs_cdb2lab,
  input  logic [VAL_WIDTH-1:0]    rs_cdb2val,
  input  logic                    lsb_cdb_en,
  input  logic [ROB_ID_WIDTH:0]   lsb_cdb2lab,
  input  logic [VAL_WIDTH-1:0]    lsb_cdb2val,
  input  logic                    br_en,
  input  logic [ROB_ID_WIDTH:0]   br_lab,
  input  logic                    br_mispredict,
  input  logic [ADDR_WIDTH-1:0]   br_target,
  output logic                    commit_en,
  output logic [ROB_ID_WIDTH:0]   commit_lab,
  output logic [VAL_WIDTH-1:0]    commit_val,
  output logic [4:0]              commit_rd,
  output logic                    commit_store,
  output logic                    flush,
  output logic [ADDR_WIDTH-1:0]   rob2if_pc
);

  localparam int ROB_SIZE = 1 << ROB_ID_WIDTH;

  typedef logic [ROB_ID_WIDTH-1:0] idx_t;
  typedef logic [ROB_ID_WIDTH:0]   tag_t;

  localparam tag_t FULL_CNT = {1'b1, {ROB_ID_WIDTH{1'b0}}};

  // Tags are 1-based so that 0 can mean "no dependency".
  function automatic idx_t tag2idx(input tag_t t);
    return idx_t'(t - tag_t'(1));
  endfunction

  function automatic tag_t idx2tag(input idx_t i);
    return {1'b0, i} + tag_t'(1);
  endfunction

  logic                  busy_q [ROB_SIZE];
  logic                  busy_d [ROB_SIZE];
  logic                  ready_q [ROB_SIZE];
  logic                  ready_d [ROB_SIZE];
  logic [4:0]            rd_q [ROB_SIZE];
  logic [4:0]            rd_d [ROB_SIZE];
  logic [VAL_WIDTH-1:0]  value_q [ROB_SIZE];
  logic [VAL_WIDTH-1:0]  value_d [ROB_SIZE];
  logic                  is_store_q [ROB_SIZE];
  logic                  is_store_d [ROB_SIZE];
  logic                  is_branch_q [ROB_SIZE];
  logic                  is_branch_d [ROB_SIZE];
  logic                  mispredict_q [ROB_SIZE];
  logic                  mispredict_d [ROB_SIZE];
  logic [ADDR_WIDTH-1:0] target_q [ROB_SIZE];
  logic [ADDR_WIDTH-1:0] target_d [ROB_SIZE];

  idx_t head_q, head_d, tail_q, tail_d;
  tag_t count_q, count_d;

  logic                  commit_en_q, commit_en_d;
  tag_t                  commit_lab_q, commit_lab_d;
  logic [VAL_WIDTH-1:0]  commit_val_q, commit_val_d;
  logic [4:0]            commit_rd_q, commit_rd_d;
  logic                  commit_store_q, commit_store_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  assign rob_full     = (count_q == FULL_CNT);
  assign newTag       = idx2tag(tail_q);
  assign commit_en    = commit_en_q;
  assign commit_lab   = commit_lab_q;
  assign commit_val   = commit_val_q;
  assign commit_rd    = commit_rd_q;
  assign commit_store = commit_store_q;
  assign flush        = flush_q;
  assign rob2if_pc    = pc_q;

  tag_t                 q_lab [2];
  logic                 q_ready [2];
  logic [VAL_WIDTH-1:0] q_res [2];

  assign q_lab[0] = q_lab1;
  assign q_lab[1] = q_lab2;
  assign ready1   = q_ready[0];
  assign ready2   = q_ready[1];
  assign res1     = q_res[0];
  assign res2     = q_res[1];

  // Operand lookup with same-cycle CDB forwarding; RS port wins over LSB.
  always_comb begin
    idx_t qi;
    qi = '0;
    for (int k = 0; k < 2; k++) begin
      q_ready[k] = 1'b0;
      q_res[k]   = '0;
      qi         = tag2idx(q_lab[k]);
      if (q_lab[k] != '0 && busy_q[qi]) begin
        if (rs_cdb_en && rs_cdb2lab == q_lab[k]) begin
          q_ready[k] = 1'b1;
          q_res[k]   = rs_cdb2val;
        end else if (lsb_cdb_en && lsb_cdb2lab == q_lab[k]) begin
          q_ready[k] = 1'b1;
          q_res[k]   = lsb_cdb2val;
        end else if (ready_q[qi]) begin
          q_ready[k] = 1'b1;
          q_res[k]   = value_q[qi];
        end
      end
    end
  end

  // Next-state: CDB capture, branch resolution, retire, allocate, flush.
  always_comb begin
    idx_t ri, li, bi;
    logic do_commit, do_issue, do_flush;

    busy_d       = busy_q;
    ready_d      = ready_q;
    rd_d         = rd_q;
    value_d      = value_q;
    is_store_d   = is_store_q;
    is_branch_d  = is_branch_q;
    mispredict_d = mispredict_q;
    target_d     = target_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;

    commit_en_d    = 1'b0;
    commit_store_d = 1'b0;
    flush_d        = 1'b0;
    commit_lab_d   = commit_lab_q;
    commit_val_d   = commit_val_q;
    commit_rd_d    = commit_rd_q;
    pc_d           = pc_q;

    ri = tag2idx(rs_cdb2lab);
    li = tag2idx(lsb_cdb2lab);
    bi = tag2idx(br_lab);

    do_commit = busy_q[head_q] && ready_q[head_q];
    do_issue  = dec2rob_en && !rob_full;
    do_flush  = do_commit && is_branch_q[head_q] && mispredict_q[head_q];

    if (rdy_in) begin
      // LSB is applied first so RS wins a same-tag collision, matching forwarding.
      if (lsb_cdb_en && lsb_cdb2lab != '0 && busy_q[li]) begin
        value_d[li] = lsb_cdb2val;
        ready_d[li] = 1'b1;
      end
      if (rs_cdb_en && rs_cdb2lab != '0 && busy_q[ri]) begin
        value_d[ri] = rs_cdb2val;
        ready_d[ri] = 1'b1;
      end
      if (br_en && br_lab != '0 && busy_q[bi]) begin
        mispredict_d[bi] = br_mispredict;
        target_d[bi]     = br_target;
      end

      if (do_commit) begin
        commit_en_d    = 1'b1;
        commit_lab_d   = idx2tag(head_q);
        commit_val_d   = value_q[head_q];
        commit_rd_d    = rd_q[head_q];
        commit_store_d = is_store_q[head_q];
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + idx_t'(1);
      end

      if (do_issue) begin
        busy_d[tail_q]       = 1'b1;
        ready_d[tail_q]      = 1'b0;
        mispredict_d[tail_q] = 1'b0;
        rd_d[tail_q]         = dec_rd;
        is_store_d[tail_q]   = dec_is_store;
        is_branch_d[tail_q]  = dec_is_branch;
        tail_d               = tail_q + idx_t'(1);
      end

      case ({do_issue, do_commit})
        2'b10:   count_d = count_q + tag_t'(1);
        2'b01:   count_d = count_q - tag_t'(1);
        default: count_d = count_q;
      endcase

      // Wrong-path work is dropped wholesale, including this edge's issue/CDB.
      if (do_flush) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          busy_d[i]       = 1'b0;
          ready_d[i]      = 1'b0;
          mispredict_d[i] = 1'b0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        flush_d = 1'b1;
        pc_d    = target_q[head_q];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]       <= 1'b0;
        ready_q[i]      <= 1'b0;
        rd_q[i]         <= '0;
        value_q[i]      <= '0;
        is_store_q[i]   <= 1'b0;
        is_branch_q[i]  <= 1'b0;
        mispredict_q[i] <= 1'b0;
        target_q[i]     <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_lab_q   <= '0;
      commit_val_q   <= '0;
      commit_rd_q    <= '0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;
      pc_q           <= '0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      is_store_q     <= is_store_d;
      is_branch_q    <= is_branch_d;
      mispredict_q   <= mispredict_d;
      target_q       <= target_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_en_q    <= commit_en_d;
      commit_lab_q   <= commit_lab_d;
      commit_val_q   <= commit_val_d;
      commit_rd_q    <= commit_rd_d;
      commit_store_q <= commit_store_d;
      flush_q        <= flush_d;
      pc_q           <= pc_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue, in-order commit, full/wrap,
// forwarding, mispredict flush and stalled store commit.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in;
  logic        dec2rob_en, dec_is_store, dec_is_branch;
  logic [4:0]  dec_rd;
  logic        rob_full;
  logic [3:0]  newTag, q_lab1, q_lab2;
  logic        ready1, ready2;
  logic [31:0] res1, res2;
  logic        rs_cdb_en, lsb_cdb_en, br_en, br_mispredict;
  logic [3:0]  rs_cdb2lab, lsb_cdb2lab, br_lab;
  logic [31:0] rs_cdb2val, lsb_cdb2val, br_target;
  logic        commit_en, commit_store, flush;
  logic [3:0]  commit_lab;
  logic [31:0] commit_val, rob2if_pc;
  logic [4:0]  commit_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec2rob_en(dec2rob_en), .dec_rd(dec_rd),
    .dec_is_store(dec_is_store), .dec_is_branch(dec_is_branch),
    .rob_full(rob_full), .newTag(newTag),
    .q_lab1(q_lab1), .q_lab2(q_lab2),
    .ready1(ready1), .ready2(ready2), .res1(res1), .res2(res2),
    .rs_cdb_en(rs_cdb_en), .rs_cdb2lab(rs_cdb2lab), .rs_cdb2val(rs_cdb2val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb2lab(lsb_cdb2lab), .lsb_cdb2val(lsb_cdb2val),
    .br_en(br_en), .br_lab(br_lab), .br_mispredict(br_mispredict), .br_target(br_target),
    .commit_en(commit_en), .commit_lab(commit_lab), .commit_val(commit_val),
    .commit_rd(commit_rd), .commit_store(commit_store),
    .flush(flush), .rob2if_pc(rob2if_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec2rob_en = 0; dec_rd = 0; dec_is_store = 0; dec_is_branch = 0;
    q_lab1 = 0; q_lab2 = 0;
    rs_cdb_en = 0; rs_cdb2lab = 0; rs_cdb2val = 0;
    lsb_cdb_en = 0; lsb_cdb2lab = 0; lsb_cdb2val = 0;
    br_en = 0; br_lab = 0; br_mispredict = 0; br_target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy_in = 1; rst_in = 1;
    tick(); tick();
    rst_in = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL reset_commit_en got %0b want 0", commit_en); end
    checks++; if (commit_store !== 1'b0) begin errors++; $display("FAIL reset_commit_store got %0b want 0", commit_store); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", flush); end
    checks++; if (commit_lab !== 4'd0 || commit_val !== 32'd0 || commit_rd !== 5'd0) begin
      errors++; $display("FAIL reset_commit_fields got lab=%0d val=%0h rd=%0d want 0", commit_lab, commit_val, commit_rd); end
    checks++; if (rob2if_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %0h want 0", rob2if_pc); end
    checks++; if (newTag !== 4'd1) begin errors++; $display("FAIL reset_newTag got %0d want 1", newTag); end
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", rob_full); end
  endtask

  task automatic test_issue();
    for (int i = 0; i < 3; i++) begin
      dec2rob_en = 1; dec_rd = 5'(i + 1);
      checks++; if (newTag !== 4'(i + 1)) begin errors++; $display("FAIL issue_newTag got %0d want %0d", newTag, i + 1); end
      tick();
      checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL issue_no_commit got %0b want 0", commit_en); end
    end
    dec2rob_en = 0;
    checks++; if (newTag !== 4'd4) begin errors++; $display("FAIL issue_newTag_end got %0d want 4", newTag); end
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL issue_full got %0b want 0", rob_full); end
  endtask

  task automatic test_inorder();
    rs_cdb_en = 1; rs_cdb2lab = 2; rs_cdb2val = 32'h22;
    tick();
    rs_cdb_en = 0;
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL inorder_tag2_held got %0b want 0", commit_en); end
    lsb_cdb_en = 1; lsb_cdb2lab = 1; lsb_cdb2val = 32'h11;
    tick();
    lsb_cdb_en = 0;
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL inorder_latency got %0b want 0", commit_en); end
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || commit_rd !== 5'd1 || commit_val !== 32'h11) begin
      errors++; $display("FAIL inorder_first got en=%0b lab=%0d rd=%0d val=%0h want 1/1/1/11", commit_en, commit_lab, commit_rd, commit_val); end
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd2 || commit_rd !== 5'd2 || commit_val !== 32'h22) begin
      errors++; $display("FAIL inorder_second got en=%0b lab=%0d rd=%0d val=%0h want 1/2/2/22", commit_en, commit_lab, commit_rd, commit_val); end
    tick();
    checks++; if (commit_en !== 1'b0) begin errors++; $display("FAIL inorder_tag3_pending got %0b want 0", commit_en); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dec2rob_en = 1; dec_rd = 5'(i + 1);
      tick();
    end
    checks++; if (rob_full !== 1'b1 || newTag !== 4'd1) begin
      errors++; $display("FAIL full_after8 got full=%0b tag=%0d want 1/1", rob_full, newTag); end
    dec_rd = 5'd31;
    tick();
    dec2rob_en = 0;
    checks++; if (rob_full !== 1'b1 || newTag !== 4'd1) begin
      errors++; $display("FAIL full_ignore9 got full=%0b tag=%0d want 1/1", rob_full, newTag); end
    rs_cdb_en = 1; rs_cdb2lab = 1; rs_cdb2val = 32'h5;
    tick();
    rs_cdb_en = 0;
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || commit_rd !== 5'd1 || commit_val !== 32'h5) begin
      errors++; $display("FAIL full_head_commit got en=%0b lab=%0d rd=%0d val=%0h want 1/1/1/5", commit_en, commit_lab, commit_rd, commit_val); end
    checks++; if (rob_full !== 1'b0 || newTag !== 4'd1) begin
      errors++; $display("FAIL full_freed got full=%0b tag=%0d want 0/1", rob_full, newTag); end
    dec2rob_en = 1; dec_rd = 5'd9;
    tick();
    dec2rob_en = 0;
    checks++; if (rob_full !== 1'b1 || newTag !== 4'd2 || commit_en !== 1'b0) begin
      errors++; $display("FAIL wrap_issue got full=%0b tag=%0d en=%0b want 1/2/0", rob_full, newTag, commit_en); end
    q_lab1 = 1; #1;
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL wrap_entry_not_ready got %0b want 0", ready1); end
    q_lab1 = 0;
  endtask

  task automatic test_forward();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dec2rob_en = 1; dec_rd = 5'(i + 1);
      tick();
    end
    dec2rob_en = 0;
    rs_cdb_en = 1; rs_cdb2lab = 5; rs_cdb2val = 32'hAB;
    lsb_cdb_en = 1; lsb_cdb2lab = 4; lsb_cdb2val = 32'hCD;
    q_lab1 = 5; q_lab2 = 0; #1;
    checks++; if (ready1 !== 1'b1 || res1 !== 32'hAB) begin
      errors++; $display("FAIL fwd_rs got rdy=%0b res=%0h want 1/ab", ready1, res1); end
    checks++; if (ready2 !== 1'b0 || res2 !== 32'h0) begin
      errors++; $display("FAIL fwd_tag0 got rdy=%0b res=%0h want 0/0", ready2, res2); end
    q_lab2 = 4; #1;
    checks++; if (ready2 !== 1'b1 || res2 !== 32'hCD) begin
      errors++; $display("FAIL fwd_lsb got rdy=%0b res=%0h want 1/cd", ready2, res2); end
    tick();
    rs_cdb_en = 0; lsb_cdb_en = 0; #1;
    checks++; if (ready1 !== 1'b1 || res1 !== 32'hAB || ready2 !== 1'b1 || res2 !== 32'hCD) begin
      errors++; $display("FAIL fwd_stored got r1=%0b v1=%0h r2=%0b v2=%0h want 1/ab/1/cd", ready1, res1, ready2, res2); end
    rs_cdb_en = 1; rs_cdb2lab = 3; rs_cdb2val = 32'h1;
    lsb_cdb_en = 1; lsb_cdb2lab = 3; lsb_cdb2val = 32'h2;
    q_lab1 = 3; q_lab2 = 7; #1;
    checks++; if (ready1 !== 1'b1 || res1 !== 32'h1) begin
      errors++; $display("FAIL fwd_priority got rdy=%0b res=%0h want 1/1", ready1, res1); end
    checks++; if (ready2 !== 1'b0 || res2 !== 32'h0) begin
      errors++; $display("FAIL fwd_not_busy got rdy=%0b res=%0h want 0/0", ready2, res2); end
    rs_cdb_en = 0; lsb_cdb_en = 0; q_lab2 = 2; #1;
    checks++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
      errors++; $display("FAIL fwd_pending got r1=%0b r2=%0b want 0/0", ready1, ready2); end
    q_lab1 = 0; q_lab2 = 0;
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dec2rob_en = 1; dec_rd = 5'(i + 1); dec_is_branch = (i == 1);
      tick();
    end
    dec2rob_en = 0; dec_is_branch = 0;
    lsb_cdb_en = 1; lsb_cdb2lab = 1; lsb_cdb2val = 32'h11;
    br_en = 1; br_lab = 2; br_mispredict = 1; br_target = 32'h100;
    tick();
    lsb_cdb_en = 0; br_en = 0;
    rs_cdb_en = 1; rs_cdb2lab = 2; rs_cdb2val = 32'h22;
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || flush !== 1'b0) begin
      errors++; $display("FAIL br_prior_commit got en=%0b lab=%0d flush=%0b want 1/1/0", commit_en, commit_lab, flush); end
    rs_cdb2lab = 3; rs_cdb2val = 32'h33;
    dec2rob_en = 1; dec_rd = 5;
    tick();
    rs_cdb_en = 0;
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd2 || commit_val !== 32'h22) begin
      errors++; $display("FAIL br_commit got en=%0b lab=%0d val=%0h want 1/2/22", commit_en, commit_lab, commit_val); end
    checks++; if (flush !== 1'b1 || rob2if_pc !== 32'h100) begin
      errors++; $display("FAIL br_flush got flush=%0b pc=%0h want 1/100", flush, rob2if_pc); end
    checks++; if (newTag !== 4'd1 || rob_full !== 1'b0) begin
      errors++; $display("FAIL br_empty got tag=%0d full=%0b want 1/0", newTag, rob_full); end
    dec_rd = 7;
    tick();
    dec2rob_en = 0;
    checks++; if (flush !== 1'b0 || commit_en !== 1'b0 || newTag !== 4'd2) begin
      errors++; $display("FAIL br_after got flush=%0b en=%0b tag=%0d want 0/0/2", flush, commit_en, newTag); end
    q_lab1 = 3; q_lab2 = 1; #1;
    checks++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
      errors++; $display("FAIL br_dropped got r3=%0b r1=%0b want 0/0", ready1, ready2); end
    q_lab1 = 0; q_lab2 = 0;
    rs_cdb_en = 1; rs_cdb2lab = 1; rs_cdb2val = 32'h77;
    tick();
    rs_cdb_en = 0;
    tick();
    checks++; if (commit_en !== 1'b1 || commit_lab !== 4'd1 || commit_rd !== 5'd7 || commit_val !== 32'h77 || flush !== 1'b0) begin
      errors++; $display("FAIL br_refill got en=%0b lab=%0d rd=%0d val=%0h fl=%0b want 1/1/7/77/0", commit_en, commit_lab, commit_rd, commit_val, flush); end
  endtask

  task automatic test_store_stall();
    do_reset();
    dec2rob_en = 1; dec_is_store = 1; dec_rd = 0;
    tick();
    dec2rob_en = 0; dec_is_store = 0;
    rs_cdb_en = 1; rs_cdb2lab = 1; rs_cdb2val = 32'h55;
    tick();
    rs_cdb_en = 0;
    rdy_in = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (commit_en !== 1'b0 || commit_store !== 1'b0) begin
        errors++; $display("FAIL stall_hold got en=%0b st=%0b want 0/0", commit_en, commit_store); end
    end
    q_lab1 = 1; #1;
    checks++; if (ready1 !== 1'b1 || res1 !== 32'h55 || newTag !== 4'd2) begin
      errors++; $display("FAIL stall_state got rdy=%0b res=%0h tag=%0d want 1/55/2", ready1, res1, newTag); end
    q_lab1 = 0;
    rdy_in = 1;
    tick();
    checks++; if (commit_en !== 1'b1 || commit_store !== 1'b1 || commit_lab !== 4'd1 || commit_val !== 32'h55) begin
      errors++; $display("FAIL store_commit got en=%0b st=%0b lab=%0d val=%0h want 1/1/1/55", commit_en, commit_store, commit_lab, commit_val); end
    tick();
    checks++; if (commit_en !== 1'b0 || commit_store !== 1'b0) begin
      errors++; $display("FAIL store_once got en=%0b st=%0b want 0/0", commit_en, commit_store); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_inorder();
    test_full_wrap();
    test_forward();
    test_mispredict();
    test_store_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
